bit_serial_subtractor: RTL and testbench
========================================

BIT_SERIAL_SUBTRACTOR -- requirements
Module: bit_serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request to begin a subtraction; sampled each rising edge.
REQ-005 a  input  WIDTH  minuend; sampled only on an accepted start.
REQ-006 b  input  WIDTH  subtrahend; sampled only on an accepted start.
REQ-007 busy  output  1  high while an operation is in progress (RUN or DONE).
REQ-008 done  output  1  one-cycle pulse; high when diff/borrow_out/zero update.
REQ-009 diff  output  WIDTH  registered result, (a - b) mod 2^WIDTH.
REQ-010 borrow_out  output  1  registered final borrow; 1 when a < b (unsigned).
REQ-011 zero  output  1  registered flag; 1 when diff == 0.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-013 In IDLE with start=1 at an edge, the block SHALL latch a and b into shift registers, clear the borrow register and the bit counter, and enter RUN.
REQ-014 start SHALL be ignored in RUN and DONE; no queuing and no operand re-latch.
REQ-015 Each RUN cycle SHALL process one bit pair (a_i, b_i), LSB first, i = 0..WIDTH-1.
REQ-016 The per-bit cell SHALL be two cascaded half-subtractor stages: d = a_i ^ b_i ^ br; br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
REQ-017 Each result bit SHALL shift into the MSB of an internal accumulator, with a right shift per RUN cycle.
REQ-018 On the edge that processes bit WIDTH-1, the block SHALL load diff from the accumulator, borrow_out from br_next and zero from (result == 0), and enter DONE.
REQ-019 done SHALL be 1 only in DONE, which lasts exactly one cycle and then returns to IDLE.
REQ-020 Latency: for start accepted at edge k, done SHALL be high between edges k+WIDTH and k+WIDTH+1; throughput is one operation per WIDTH+2 cycles.
REQ-021 busy SHALL equal 1 in RUN and DONE and 0 in IDLE.
REQ-022 diff, borrow_out and zero SHALL hold their values until the next DONE entry or reset; an accepted start SHALL NOT clear them.
REQ-023 Holding start high continuously SHALL start a new operation on the first IDLE edge after each DONE.
REQ-024 Changes on a/b after acceptance SHALL NOT affect the operation in progress.
REQ-025 The result SHALL wrap modulo 2^WIDTH, with no saturation.

Reset
REQ-026 With rst_n=0 at a rising edge, the block SHALL enter IDLE and set busy, done, diff, borrow_out, zero, the accumulator, the borrow register and the counter to 0.
REQ-027 Reset SHALL take priority over start and over any state, including mid-RUN; a partial result SHALL be discarded and no done pulse produced.
REQ-028 Reset SHALL be sampled only on clk edges; the block SHALL have no asynchronous path.

Verification (WIDTH=8)
REQ-029 a=0x05, b=0x03, start pulse -> done 9 cycles later; diff=0x02, borrow_out=0, zero=0.
REQ-030 a=0x03, b=0x05 -> diff=0xFE, borrow_out=1, zero=0; a=0x00, b=0x01 -> diff=0xFF, borrow_out=1.
REQ-031 a=0xA7, b=0xA7 -> diff=0x00, borrow_out=0, zero=1; a=0x80, b=0x7F -> diff=0x01, borrow_out=0.
REQ-032 Start 0x10-0x01; pulse start with a=0xFF, b=0x00 during RUN, and change a/b mid-op -> single done, diff=0x0F, no second op.
REQ-033 Start high continuously with a=0x05, b=0x03 -> done pulses every 10 cycles; busy low exactly one cycle between ops.
REQ-034 rst_n=0 at RUN bit 4 -> next cycle busy=0, done=0, diff=0x00; no done pulse; a new start then completes normally.

Source files
------------

// File: rtl/bit_serial_subtractor_if.sv
`default_nettype none
// ============================================================================
// Module   : bit_serial_subtractor_if
// Brief    : Operand/handshake/result bundle for the bit-serial subtractor.
// Revision : 1.0
// ============================================================================
interface bit_serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             zero;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out, zero
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out, zero
  );
endinterface
`default_nettype wire

// File: rtl/bit_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : bit_serial_subtractor
// Brief    : LSB-first serial subtractor, one bit per cycle, (a - b) mod 2^WIDTH.
// Revision : 1.0
// ============================================================================
module bit_serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  wire logic                clk,
  input  wire logic                rst_n,
  bit_serial_subtractor_if.slave   bus
);

  localparam int c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_busy;
  logic               w_done;

  logic [WIDTH-1:0]   r_a_sr;
  logic [WIDTH-1:0]   r_b_sr;
  logic [WIDTH-1:0]   r_acc;
  logic               r_br;
  logic [c_CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_diff;
  logic               r_borrow_out;
  logic               r_zero;

  logic               w_accept;
  logic               w_run;
  logic               w_last;
  logic               w_ai;
  logic               w_bi;
  logic               w_x;
  logic               w_d;
  logic               w_br_nxt;
  logic [WIDTH-1:0]   w_result;

  assign w_accept = (r_state == S_IDLE) && bus.start;
  assign w_run    = (r_state == S_RUN);
  assign w_last   = w_run && (r_cnt == c_LAST);

  // Two cascaded half-subtractors: first a-b, then subtract the incoming borrow.
  assign w_ai     = r_a_sr[0];
  assign w_bi     = r_b_sr[0];
  assign w_x      = w_ai ^ w_bi;
  assign w_d      = w_x ^ r_br;
  assign w_br_nxt = (~w_ai & w_bi) | (~w_x & r_br);
  assign w_result = {w_d, r_acc[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_busy = 1'b1;
        if (r_cnt == c_LAST) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_busy      = 1'b1;
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a_sr       <= '0;
      r_b_sr       <= '0;
      r_acc        <= '0;
      r_br         <= 1'b0;
      r_cnt        <= '0;
      r_diff       <= '0;
      r_borrow_out <= 1'b0;
      r_zero       <= 1'b0;
    end else if (w_accept) begin
      // Result registers are left alone so the previous answer stays visible.
      r_a_sr <= bus.a;
      r_b_sr <= bus.b;
      r_acc  <= '0;
      r_br   <= 1'b0;
      r_cnt  <= '0;
    end else if (w_run) begin
      r_a_sr <= r_a_sr >> 1;
      r_b_sr <= r_b_sr >> 1;
      r_acc  <= w_result;
      r_br   <= w_br_nxt;
      r_cnt  <= r_cnt + c_CNT_W'(1);
      if (w_last) begin
        r_diff       <= w_result;
        r_borrow_out <= w_br_nxt;
        r_zero       <= (w_result == '0);
      end
    end
  end

  assign bus.busy       = w_busy;
  assign bus.done       = w_done;
  assign bus.diff       = r_diff;
  assign bus.borrow_out = r_borrow_out;
  assign bus.zero       = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_bit_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_bit_serial_subtractor
// Brief    : Vector table, random ops against an arithmetic model, corner sequences.
// Revision : 1.0
// ============================================================================
module tb_bit_serial_subtractor;

  localparam int WIDTH = 8;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  bit_serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

  bit_serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             zero;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one operation, scramble operands after acceptance, check result and timing.
  task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic [WIDTH-1:0] ed, input logic eb, input logic ez);
    int cyc;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = WIDTH'($urandom);
    bus.b     = WIDTH'($urandom);
    check("busy_after_start", 32'(bus.busy), 32'd1);
    cyc = 0;
    while (!bus.done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("latency", 32'(cyc), 32'(WIDTH));
    check("diff", 32'(bus.diff), 32'(ed));
    check("borrow_out", 32'(bus.borrow_out), 32'(eb));
    check("zero", 32'(bus.zero), 32'(ez));
    check("busy_at_done", 32'(bus.busy), 32'd1);
    @(negedge clk);
    check("done_one_cycle", 32'(bus.done), 32'd0);
    check("busy_idle", 32'(bus.busy), 32'd0);
    check("diff_hold", 32'(bus.diff), 32'(ed));
  endtask

  // Reference: plain modular arithmetic on the operands.
  task automatic run_model_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    int unsigned ua;
    int unsigned ub;
    int unsigned m;
    logic [WIDTH-1:0] ed;
    ua = int'(av);
    ub = int'(bv);
    m  = (ua + (32'd1 << WIDTH) - ub) % (32'd1 << WIDTH);
    ed = WIDTH'(m);
    run_op(av, bv, ed, ua < ub, m == 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lows;
    int last_done;
    int ndone;
    int cyc;
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;

    vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'hA7, 8'hA7, 8'h00, 1'b0, 1'b1};
    vecs[4] = '{8'h80, 8'h7F, 8'h01, 1'b0, 1'b0};
    vecs[5] = '{8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0};
    vecs[6] = '{8'h00, 8'hFF, 8'h01, 1'b1, 1'b0};

    // Reset state, with start asserted to show reset wins.
    bus.start = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_diff", 32'(bus.diff), 32'd0);
    check("rst_borrow", 32'(bus.borrow_out), 32'd0);
    check("rst_zero", 32'(bus.zero), 32'd0);
    bus.start = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].borrow, vecs[i].zero);
    end

    for (int i = 0; i < 40; i++) begin
      run_model_op(WIDTH'($urandom), WIDTH'($urandom));
    end

    // Start ignored mid-run; operands changing mid-run have no effect.
    run_op(8'h3C, 8'h11, 8'h2B, 1'b0, 1'b0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h10;
    bus.b     = 8'h01;
    @(negedge clk);
    bus.start = 1'b0;
    check("diff_kept_on_start", 32'(bus.diff), 32'h2B);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'hFF;
    bus.b     = 8'h00;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = 8'h55;
    bus.b     = 8'hAA;
    cyc = 0;
    while (!bus.done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("ignore_done_seen", 32'(bus.done), 32'd1);
    check("ignore_diff", 32'(bus.diff), 32'h0F);
    check("ignore_borrow", 32'(bus.borrow_out), 32'd0);
    ndone = 0;
    lows  = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.done) ndone++;
      if (bus.busy) lows++;
    end
    check("no_second_done", 32'(ndone), 32'd0);
    check("no_second_busy", 32'(lows), 32'd0);

    // Start held high: back-to-back operations every WIDTH+2 cycles.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h05;
    bus.b     = 8'h03;
    lows      = 0;
    last_done = -1;
    ndone     = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (bus.done) begin
        ndone++;
        check("cont_diff", 32'(bus.diff), 32'h02);
        if (last_done >= 0) begin
          check("cont_period", 32'(i - last_done), 32'(WIDTH + 2));
          check("cont_busy_gap", 32'(lows), 32'd1);
        end
        last_done = i;
        lows      = 0;
      end else if (!bus.busy && last_done >= 0) begin
        lows++;
      end
    end
    check("cont_count", 32'(ndone >= 4), 32'd1);
    cyc = 0;
    while (!bus.done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("cont_stop_idle", 32'(bus.busy), 32'd0);

    // Reset mid-run discards the partial result and suppresses done.
    run_op(8'h01, 8'h03, 8'hFE, 1'b1, 1'b0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h40;
    bus.b     = 8'h01;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_diff", 32'(bus.diff), 32'd0);
    check("midrst_borrow", 32'(bus.borrow_out), 32'd0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) ndone++;
    end
    check("midrst_quiet", 32'(ndone), 32'd0);
    run_op(8'h40, 8'h01, 8'h3F, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
